pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage of the RV32I core.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request, response-valid handshake.
- Presents the fetched instruction to decode, and on each retire computes the next PC from the branch decision `NextPCSrc` (produced by the branch unit) and the ALU target.
- Detects misaligned control-flow targets and counts retired instructions.

---
 rtl/pc_fetch_unit.sv | 101 ++++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32I program counter and instruction fetch stage
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             NextPCSrc,
    input  logic [31:0]      BranchTarget,
    input  logic             Commit,
    input  logic             Stall,
    output logic             ImemReqValid,
    output logic [31:0]      ImemAddr,
    input  logic             ImemReady,
    input  logic             ImemRspValid,
    input  logic [31:0]      ImemRspData,
    output logic [31:0]      Inst,
    output logic             InstValid,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             MisalignedTrap,
    output logic [31:0]      TrapAddr,
    output logic [CNT_W-1:0] RetireCount
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        TRAP
    } state_t;

    state_t      state;
    logic        req_pending;
    logic        accept;
    logic [31:0] next_target;

    // A request that was presented but not yet accepted must survive a stall.
    assign ImemReqValid = (state == FETCH) && (!Stall || req_pending);
    assign ImemAddr     = PC;
    assign PCPlus4      = PC + 32'd4;
    assign accept       = (state == ISSUE) && Commit && !Stall;
    assign next_target  = NextPCSrc ? (BranchTarget & ~32'd1) : PCPlus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_pending    <= 1'b0;
            PC             <= RESET_PC;
            Inst           <= NOP;
            InstValid      <= 1'b0;
            MisalignedTrap <= 1'b0;
            TrapAddr       <= 32'd0;
            RetireCount    <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    req_pending <= ImemReqValid && !ImemReady;
                    if (ImemReqValid && ImemReady) begin
                        if (ImemRspValid) begin
                            Inst      <= ImemRspData;
                            InstValid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ImemRspValid) begin
                        Inst      <= ImemRspData;
                        InstValid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        RetireCount <= RetireCount + {{(CNT_W-1){1'b0}}, 1'b1};
                        InstValid   <= 1'b0;
                        // Misaligned target: PC stays on the faulting instruction.
                        if (next_target[1]) begin
                            MisalignedTrap <= 1'b1;
                            TrapAddr       <= next_target;
                            state          <= TRAP;
                        end else begin
                            PC    <= next_target;
                            state <= FETCH;
                        end
                    end
                end
                TRAP: state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        NextPCSrc;
    logic [31:0] BranchTarget;
    logic        Commit;
    logic        Stall;
    logic        ImemReqValid;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] Inst;
    logic        InstValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignedTrap;
    logic [31:0] TrapAddr;
    logic [3:0]  RetireCount;

    pc_fetch_unit #(.RESET_PC(32'h100), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .NextPCSrc(NextPCSrc), .BranchTarget(BranchTarget),
        .Commit(Commit), .Stall(Stall), .ImemReqValid(ImemReqValid), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .Inst(Inst), .InstValid(InstValid), .PC(PC), .PCPlus4(PCPlus4),
        .MisalignedTrap(MisalignedTrap), .TrapAddr(TrapAddr), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_trap;
    logic [31:0] m_taddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h100; m_cnt = 0; m_trap = 1'b0; m_taddr = 32'd0;
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"}, PC, m_pc);
        check({tag, "_pc4"}, PCPlus4, m_pc + 32'd4);
        check({tag, "_cnt"}, {28'd0, RetireCount}, 32'(m_cnt));
        check({tag, "_trap"}, {31'd0, MisalignedTrap}, {31'd0, m_trap});
        check({tag, "_taddr"}, TrapAddr, m_taddr);
    endtask

    // Entered at a negedge with the DUT in FETCH.
    task automatic fetch_one(input logic [31:0] data, input int rdly, input int pdly, input int spre);
        for (int i = 0; i < spre; i++) begin
            Stall = 1'b1;
            #1 check("stall_noreq", {31'd0, ImemReqValid}, 32'd0);
            @(negedge clk);
        end
        Stall = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            if (i > 0) Stall = 1'($urandom_range(0, 1));
            ImemReady    = (i == rdly);
            ImemRspValid = (i == rdly) ? (pdly == 0) : 1'($urandom_range(0, 1));
            ImemRspData  = (i == rdly) ? data : $urandom;
            #1;
            check("req_valid", {31'd0, ImemReqValid}, 32'd1);
            check("req_addr", ImemAddr, m_pc);
            if (i < rdly) @(negedge clk);
        end
        @(negedge clk);
        ImemReady = 1'b0; ImemRspValid = 1'b0; Stall = 1'b0;
        for (int j = 0; j < pdly; j++) begin
            ImemRspData = $urandom;
            #1;
            check("wait_noinst", {31'd0, InstValid}, 32'd0);
            check("wait_noreq", {31'd0, ImemReqValid}, 32'd0);
            @(negedge clk);
        end
        if (pdly > 0) begin
            ImemRspValid = 1'b1; ImemRspData = data;
            @(negedge clk);
            ImemRspValid = 1'b0;
        end
        #1;
        check("inst_valid", {31'd0, InstValid}, 32'd1);
        check("inst", Inst, data);
        check("issue_pc", PC, m_pc);
    endtask

    // Entered at a negedge with the DUT in ISSUE.
    task automatic commit_one(input logic src, input logic [31:0] tgt, input int nstall);
        logic [31:0] t;
        for (int k = 0; k < nstall; k++) begin
            Commit = 1'b1; Stall = 1'b1; NextPCSrc = src; BranchTarget = tgt;
            @(negedge clk);
            #1;
            check("stall_commit_pc", PC, m_pc);
            check("stall_commit_cnt", {28'd0, RetireCount}, 32'(m_cnt));
            check("stall_commit_iv", {31'd0, InstValid}, 32'd1);
        end
        Commit = 1'b1; Stall = 1'b0; NextPCSrc = src; BranchTarget = tgt;
        @(negedge clk);
        Commit = 1'b0;
        t = src ? {tgt[31:1], 1'b0} : m_pc + 32'd4;
        if (t % 4 >= 2) begin
            m_trap = 1'b1; m_taddr = t;
        end else begin
            m_pc = t;
        end
        m_cnt = (m_cnt + 1) % 16;
        #1;
        check_arch("commit");
        check("commit_iv", {31'd0, InstValid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; NextPCSrc = 1'b0; BranchTarget = 32'd0; Commit = 1'b0; Stall = 1'b0;
        ImemReady = 1'b0; ImemRspValid = 1'b0; ImemRspData = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_arch("reset");
        check("reset_inst", Inst, 32'h13);
        check("reset_iv", {31'd0, InstValid}, 32'd0);
        check("reset_req", {31'd0, ImemReqValid}, 32'd0);

        rst_n = 1'b1;
        #1 check("idle_req", {31'd0, ImemReqValid}, 32'd0);
        @(negedge clk);
        fetch_one(32'h00500093, 0, 0, 0);
        commit_one(1'b0, 32'd0, 0);
        fetch_one(32'h00100113, 0, 0, 0);
        commit_one(1'b1, 32'h2001, 0);
        fetch_one($urandom, 3, 2, 1);
        commit_one(1'b0, 32'd0, 2);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] tg;
            tg = $urandom;
            tg[1] = 1'b0;
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            commit_one(1'($urandom_range(0, 1)), tg, $urandom_range(0, 2));
        end

        fetch_one($urandom, 0, 0, 0);
        commit_one(1'b1, 32'hFFFF_FFFD, 0);
        check("wrap_setup", PC, 32'hFFFF_FFFC);
        fetch_one($urandom, 1, 0, 0);
        commit_one(1'b0, 32'd0, 0);
        check("pc_wrap", PC, 32'd0);

        // Reset while a response is outstanding; stale response must be dropped.
        Stall = 1'b0; ImemReady = 1'b1; ImemRspValid = 1'b0;
        @(negedge clk);
        ImemReady = 1'b0;
        rst_n = 1'b0; ImemRspValid = 1'b1; ImemRspData = 32'hDEAD_BEEF;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_wait_inst", Inst, 32'h13);
        check("rst_wait_iv", {31'd0, InstValid}, 32'd0);
        check_arch("rst_wait");
        @(negedge clk);
        #1 check("rst_stale_iv", {31'd0, InstValid}, 32'd0);
        ImemRspValid = 1'b0;

        fetch_one(32'h0000_0067, 2, 1, 0);
        commit_one(1'b1, 32'h2002, 0);
        check("trap_flag", {31'd0, MisalignedTrap}, 32'd1);
        check("trap_addr", TrapAddr, 32'h2002);
        for (int c = 0; c < 10; c++) begin
            Commit = 1'($urandom_range(0, 1)); Stall = 1'b0; NextPCSrc = 1'b0;
            ImemReady = 1'b1; ImemRspValid = 1'b1;
            #1 check("trap_noreq", {31'd0, ImemReqValid}, 32'd0);
            @(negedge clk);
            #1;
            check("trap_iv", {31'd0, InstValid}, 32'd0);
            check_arch("trap_hold");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
